pipeline_scoreboard: RTL and testbench

Parametrised hazard, forwarding and flush controller for the pipelined datapath. It is the successor to the fixed load-use-only hazard detection. It tracks a token for every in-flight instruction from EX through WB, with a configurable stage count. It produces:
- load-use stalls with a configurable load latency,
- per-operand forwarding selects for the ID stage,
- branch flush and kill masks for younger instructions,
- retire and stall counters.

It sits beside the decode stage and drives the IF/ID and ID/EX register enables.

---
 rtl/pipeline_scoreboard.sv | 118 +++++++++++
 tb/tb_pipeline_scoreboard.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_scoreboard.sv
// Hazard, forwarding and flush controller for the in-order pipeline.
// Tracks one token per in-flight instruction from EX (slot 0) through WB (slot NUM_STAGES-1).
module pipeline_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_STAGES     = 3,
    parameter int LOAD_LATENCY   = 1,
    parameter int BRANCH_SLOT    = 1,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      branch_taken,
    output logic                      stall,
    output logic                      flush,
    output logic [NUM_STAGES-1:0]     kill_mask,
    output logic [3:0]                fwd_rs1_sel,
    output logic [3:0]                fwd_rs2_sel,
    output logic [NUM_STAGES-1:0]     stage_valid,
    output logic [CNT_WIDTH-1:0]      retire_count,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [NUM_STAGES-1:0]     slot_valid;
    logic [NUM_STAGES-1:0]     slot_reg_write;
    logic [NUM_STAGES-1:0]     slot_mem_read;
    logic [REG_ADDR_WIDTH-1:0] slot_rd [NUM_STAGES];

    logic [NUM_STAGES-1:0] writes_rs1;
    logic [NUM_STAGES-1:0] writes_rs2;
    logic                  hazard_rs1;
    logic                  hazard_rs2;
    logic                  hazard;

    // x0 is hardwired, so a slot targeting it never counts as a producer.
    always_comb begin
        writes_rs1 = '0;
        writes_rs2 = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            writes_rs1[k] = slot_valid[k] && slot_reg_write[k] &&
                            (slot_rd[k] == id_rs1) && (id_rs1 != '0);
            writes_rs2[k] = slot_valid[k] && slot_reg_write[k] &&
                            (slot_rd[k] == id_rs2) && (id_rs2 != '0);
        end
    end

    // Walk oldest to youngest so the youngest producer is the one left standing.
    always_comb begin
        fwd_rs1_sel = '0;
        fwd_rs2_sel = '0;
        hazard_rs1  = 1'b0;
        hazard_rs2  = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (id_uses_rs1 && writes_rs1[k]) begin
                fwd_rs1_sel = 4'(k + 1);
                hazard_rs1  = slot_mem_read[k] && (k < LOAD_LATENCY);
            end
            if (id_uses_rs2 && writes_rs2[k]) begin
                fwd_rs2_sel = 4'(k + 1);
                hazard_rs2  = slot_mem_read[k] && (k < LOAD_LATENCY);
            end
        end
    end

    assign hazard = id_valid && (hazard_rs1 || hazard_rs2);
    assign stall  = hazard && !branch_taken;
    assign flush  = branch_taken;

    always_comb begin
        kill_mask = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            kill_mask[j] = branch_taken && (j < BRANCH_SLOT);
        end
    end

    assign stage_valid = slot_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid     <= '0;
            slot_reg_write <= '0;
            slot_mem_read  <= '0;
            for (int j = 0; j < NUM_STAGES; j++) begin
                slot_rd[j] <= '0;
            end
            retire_count <= '0;
            stall_count  <= '0;
        end else begin
            for (int j = 1; j < NUM_STAGES; j++) begin
                slot_valid[j]     <= slot_valid[j-1] && !kill_mask[j-1];
                slot_reg_write[j] <= slot_reg_write[j-1];
                slot_mem_read[j]  <= slot_mem_read[j-1];
                slot_rd[j]        <= slot_rd[j-1];
            end
            // A stalled or flushed ID instruction leaves a bubble in EX.
            slot_valid[0]     <= id_valid && !stall && !flush;
            slot_reg_write[0] <= id_reg_write;
            slot_mem_read[0]  <= id_mem_read;
            slot_rd[0]        <= id_rd;
            if (slot_valid[NUM_STAGES-1]) begin
                retire_count <= retire_count + CNT_ONE;
            end
            if (stall) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard: default build (a) and a deeper
// build with LOAD_LATENCY=2, NUM_STAGES=4 (b) driven by the same stimulus.
module tb_pipeline_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       branch_taken;

    logic        a_stall, a_flush;
    logic [2:0]  a_kill, a_valid;
    logic [3:0]  a_fwd1, a_fwd2;
    logic [31:0] a_retire, a_stalls;

    logic        b_stall, b_flush;
    logic [3:0]  b_kill, b_valid;
    logic [3:0]  b_fwd1, b_fwd2;
    logic [31:0] b_retire, b_stalls;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_scoreboard dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .branch_taken(branch_taken),
        .stall(a_stall), .flush(a_flush), .kill_mask(a_kill),
        .fwd_rs1_sel(a_fwd1), .fwd_rs2_sel(a_fwd2), .stage_valid(a_valid),
        .retire_count(a_retire), .stall_count(a_stalls)
    );

    pipeline_scoreboard #(.NUM_STAGES(4), .LOAD_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .branch_taken(branch_taken),
        .stall(b_stall), .flush(b_flush), .kill_mask(b_kill),
        .fwd_rs1_sel(b_fwd1), .fwd_rs2_sel(b_fwd2), .stage_valid(b_valid),
        .retire_count(b_retire), .stall_count(b_stalls)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_uses_rs1  = u1;
        id_rs2       = rs2;
        id_uses_rs2  = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        branch_taken = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        branch_taken = 1'b0;
        idle();
        do_reset();

        // reset state
        check("rst_valid", a_valid, 0);
        check("rst_retire", a_retire, 0);
        check("rst_stalls", a_stalls, 0);
        check("rst_stall", a_stall, 0);
        check("rst_fwd1", a_fwd1, 0);
        check("rst_kill", a_kill, 0);
        check("rst_flush", a_flush, 0);

        // back-to-back ALU dependence
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);      // add x5
        check("alu0_stall", a_stall, 0);
        tick();
        set_id(1, 5'd5, 1, 5'd2, 1, 5'd6, 1, 0);      // sub x6, x5
        check("alu1_fwd1", a_fwd1, 1);
        check("alu1_fwd2", a_fwd2, 0);
        check("alu1_stall", a_stall, 0);
        tick();
        set_id(1, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0);      // or x7, x5, x6
        check("alu2_fwd1", a_fwd1, 2);
        check("alu2_fwd2", a_fwd2, 1);
        check("alu2_stall", a_stall, 0);
        tick();
        idle();
        repeat (4) tick();
        check("alu_retire_a", a_retire, 3);
        check("alu_retire_b", b_retire, 3);
        check("alu_drained", a_valid, 0);

        // load-use
        do_reset();
        set_id(1, 5'd1, 1, 5'd2, 0, 5'd7, 1, 1);      // lw x7
        check("ld0_stall", a_stall, 0);
        tick();
        set_id(1, 5'd7, 1, 5'd3, 1, 5'd8, 1, 0);      // add x8, x7, x3
        check("ld1_stall_a", a_stall, 1);
        check("ld1_stall_b", b_stall, 1);
        check("ld1_fwd1_a", a_fwd1, 1);
        tick();
        check("ld2_stall_a", a_stall, 0);
        check("ld2_fwd1_a", a_fwd1, 2);
        check("ld2_stall_b", b_stall, 1);
        check("ld2_cnt_a", a_stalls, 1);
        check("ld2_valid_a", a_valid, 3'b010);
        tick();
        check("ld3_stall_b", b_stall, 0);
        check("ld3_fwd1_b", b_fwd1, 3);
        check("ld3_cnt_a", a_stalls, 1);
        check("ld3_cnt_b", b_stalls, 2);
        idle();

        // branch in MEM with a pending load-use hazard
        do_reset();
        set_id(1, 5'd1, 1, 5'd2, 0, 5'd9, 1, 0);      // add x9
        tick();
        set_id(1, 5'd1, 1, 5'd2, 0, 5'd7, 1, 1);      // lw x7
        tick();
        set_id(1, 5'd7, 1, 5'd2, 0, 5'd8, 1, 0);      // dependent add
        branch_taken = 1'b1;
        #1;
        check("br_stall", a_stall, 0);
        check("br_flush", a_flush, 1);
        check("br_kill_a", a_kill, 3'b001);
        check("br_kill_b", b_kill, 4'b0001);
        tick();
        branch_taken = 1'b0;
        idle();
        check("br_valid_a", a_valid, 3'b100);
        check("br_valid_b", b_valid, 4'b0100);
        check("br_cnt_a", a_stalls, 0);
        check("br_cnt_b", b_stalls, 0);

        // x0 and multiple producers
        do_reset();
        set_id(1, 5'd1, 0, 5'd2, 0, 5'd3, 1, 0);      // add x3
        tick();
        set_id(1, 5'd1, 0, 5'd2, 0, 5'd0, 1, 0);      // add x0
        tick();
        set_id(1, 5'd1, 0, 5'd2, 0, 5'd3, 1, 0);      // add x3
        tick();
        set_id(1, 5'd3, 1, 5'd0, 1, 5'd4, 1, 0);
        check("x3_fwd1", a_fwd1, 1);
        check("x0_fwd2", a_fwd2, 0);
        set_id(1, 5'd3, 0, 5'd0, 1, 5'd4, 1, 0);
        check("unused_fwd1", a_fwd1, 0);
        idle();

        // retire count and mid-stream reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_id(1, 5'd1, 1, 5'd2, 1, 5'(10 + i), 1, 0);
            tick();
        end
        idle();
        repeat (3) tick();
        check("ret10_a", a_retire, 10);
        check("ret9_b", b_retire, 9);
        tick();
        check("ret10_b", b_retire, 10);
        set_id(1, 5'd1, 1, 5'd2, 0, 5'd7, 1, 1);      // lw x7
        tick();
        set_id(1, 5'd7, 1, 5'd2, 0, 5'd8, 1, 0);
        tick();
        check("pre_rst_cnt", a_stalls, 1);
        check("pre_rst_ret", a_retire, 10);
        reset = 1'b1;
        branch_taken = 1'b1;
        #1;
        check("rst_flush_hi", a_flush, 1);
        branch_taken = 1'b0;
        tick();
        check("mid_rst_valid_a", a_valid, 0);
        check("mid_rst_valid_b", b_valid, 0);
        check("mid_rst_ret_a", a_retire, 0);
        check("mid_rst_cnt_a", a_stalls, 0);
        check("mid_rst_cnt_b", b_stalls, 0);
        check("mid_rst_stall", b_stall, 0);
        check("mid_rst_fwd1", a_fwd1, 0);
        reset = 1'b0;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
